// File: rtl/csr_pkg.sv
// Shared definitions for the interrupt/CSR controller: CSR map, mstatus bit
// positions, mtvec mode encodings, trap FSM states and the mcause interrupt bit.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Interrupt id width: enough for the largest supported NUM_IRQ (16)
    localparam int IRQ_ID_W = 4;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_TRAP    = 2'b01,
        ST_HANDLER = 2'b10,
        ST_RET     = 2'b11
    } irq_state_e;

    // Position of the interrupt flag inside mcause for a given datapath width
    function automatic int mcause_int_bit(input int xlen);
        return xlen - 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index of pend wins.
module irq_prio_enc #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = 4
) (
    input  logic [NUM_IRQ-1:0] pend,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    // Scan from the top down so the last hit, i.e. the lowest index, sticks
    always_comb begin
        id    = {ID_W{1'b0}};
        valid = |pend;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            id = pend[i] ? ID_W'(i) : id;
        end
    end

endmodule

// File: rtl/csr_irq_ctrl.sv
// Machine-mode interrupt controller: arbitrates level interrupts, takes the trap
// at the Memory stage, holds the trap CSRs and steers fetch on entry and mret.
module csr_irq_ctrl
    import csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0004,
    parameter int          VECTORED_EN = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [XLEN-1:0]    pc_m,
    input  logic               valid_m,
    input  logic               mret_m,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               int_sel,
    output logic               int_flush,
    output logic [XLEN-1:0]    pc_int,
    output logic               in_handler
);

    localparam int MCAUSE_INT = mcause_int_bit(XLEN);

    irq_state_e          state_r, state_s;
    logic                mie_bit_r, mpie_r;
    logic [NUM_IRQ-1:0]  mie_r;
    logic [XLEN-1:0]     mtvec_r, mepc_r, mcause_r, pc_int_r;
    logic                int_sel_r, in_handler_r;

    logic [NUM_IRQ-1:0]  pend_s;
    logic                win_valid_s;
    logic [IRQ_ID_W-1:0] win_id_s;
    logic                take_s, mret_take_s, vectored_s;
    logic [XLEN-1:0]     trap_target_s, mcause_trap_s, mtvec_wdata_s;

    assign pend_s = irq_i & mie_r;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (IRQ_ID_W)
    ) u_prio_enc (
        .pend  (pend_s),
        .valid (win_valid_s),
        .id    (win_id_s)
    );

    // Trap/return decisions, handler target, trap cause and masked mtvec write data
    always_comb begin
        take_s        = (state_r == ST_IDLE) && mie_bit_r && valid_m && win_valid_s && !mret_m;
        mret_take_s   = valid_m && mret_m && ((state_r == ST_IDLE) || (state_r == ST_HANDLER));
        vectored_s    = (VECTORED_EN != 0) && (mtvec_r[1:0] == MTVEC_MODE_VECTORED);
        trap_target_s = {mtvec_r[XLEN-1:2], 2'b00}
                      + (vectored_s ? (XLEN'(win_id_s) << 2) : {XLEN{1'b0}});
        mcause_trap_s                 = {XLEN{1'b0}};
        mcause_trap_s[IRQ_ID_W-1:0]   = win_id_s;
        mcause_trap_s[MCAUSE_INT]     = 1'b1;
        mtvec_wdata_s                 = csr_wdata;
        mtvec_wdata_s[1]              = 1'b0;
        if (VECTORED_EN == 0) begin
            mtvec_wdata_s[0] = 1'b0;
        end else begin
            mtvec_wdata_s[0] = csr_wdata[0];
        end
    end

    // Trap FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_s = ST_TRAP;
                end else if (mret_take_s) begin
                    state_s = ST_RET;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TRAP: state_s = ST_HANDLER;
            ST_HANDLER: begin
                if (mret_take_s) begin
                    state_s = ST_RET;
                end else begin
                    state_s = ST_HANDLER;
                end
            end
            ST_RET:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state and registered redirect/handler outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            int_sel_r    <= 1'b0;
            in_handler_r <= 1'b0;
            pc_int_r     <= {XLEN{1'b0}};
        end else begin
            state_r      <= state_s;
            int_sel_r    <= (state_s == ST_TRAP) || (state_s == ST_RET);
            in_handler_r <= (state_s == ST_TRAP) || (state_s == ST_HANDLER);
            if (take_s) begin
                pc_int_r <= trap_target_s;
            end else if (mret_take_s) begin
                pc_int_r <= mepc_r;
            end else begin
                pc_int_r <= pc_int_r;
            end
        end
    end

    // mstatus: trap entry and return own MIE/MPIE over software writes
    always_ff @(posedge clk) begin
        if (reset) begin
            mie_bit_r <= 1'b0;
            mpie_r    <= 1'b0;
        end else if (take_s) begin
            mpie_r    <= mie_bit_r;
            mie_bit_r <= 1'b0;
        end else if (state_r == ST_RET) begin
            mie_bit_r <= mpie_r;
            mpie_r    <= 1'b1;
        end else if (csr_we && (csr_addr == CSR_MSTATUS)) begin
            mie_bit_r <= csr_wdata[MSTATUS_MIE];
            mpie_r    <= csr_wdata[MSTATUS_MPIE];
        end else begin
            mie_bit_r <= mie_bit_r;
            mpie_r    <= mpie_r;
        end
    end

    // mie and mtvec: software-owned
    always_ff @(posedge clk) begin
        if (reset) begin
            mie_r   <= {NUM_IRQ{1'b0}};
            mtvec_r <= XLEN'(MTVEC_RESET);
        end else begin
            if (csr_we && (csr_addr == CSR_MIE)) begin
                mie_r <= csr_wdata[NUM_IRQ-1:0];
            end else begin
                mie_r <= mie_r;
            end
            if (csr_we && (csr_addr == CSR_MTVEC)) begin
                mtvec_r <= mtvec_wdata_s;
            end else begin
                mtvec_r <= mtvec_r;
            end
        end
    end

    // mepc and mcause: captured on trap entry, otherwise writable by software
    always_ff @(posedge clk) begin
        if (reset) begin
            mepc_r   <= {XLEN{1'b0}};
            mcause_r <= {XLEN{1'b0}};
        end else if (take_s) begin
            mepc_r   <= pc_m;
            mcause_r <= mcause_trap_s;
        end else begin
            if (csr_we && (csr_addr == CSR_MEPC)) begin
                mepc_r <= {csr_wdata[XLEN-1:2], 2'b00};
            end else begin
                mepc_r <= mepc_r;
            end
            if (csr_we && (csr_addr == CSR_MCAUSE)) begin
                mcause_r <= csr_wdata;
            end else begin
                mcause_r <= mcause_r;
            end
        end
    end

    // Combinational CSR read port; unmapped addresses read as zero
    always_comb begin
        csr_rdata = {XLEN{1'b0}};
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE]  = mie_bit_r;
                csr_rdata[MSTATUS_MPIE] = mpie_r;
            end
            CSR_MIE:    csr_rdata = XLEN'(mie_r);
            CSR_MTVEC:  csr_rdata = mtvec_r;
            CSR_MEPC:   csr_rdata = mepc_r;
            CSR_MCAUSE: csr_rdata = mcause_r;
            CSR_MIP:    csr_rdata = XLEN'(irq_i);
            default:    csr_rdata = {XLEN{1'b0}};
        endcase
    end

    assign int_sel    = int_sel_r;
    assign int_flush  = int_sel_r;
    assign pc_int     = pc_int_r;
    assign in_handler = in_handler_r;

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Self-checking bench for csr_irq_ctrl: directed scenarios plus randomized
// traffic compared against an event-level model of the trap/CSR rules.
module tb_csr_irq_ctrl;

    localparam int XLEN    = 32;
    localparam int NUM_IRQ = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [XLEN-1:0]    pc_m;
    logic               valid_m, mret_m;
    logic [NUM_IRQ-1:0] irq_i;
    logic               csr_we;
    logic [11:0]        csr_addr;
    logic [XLEN-1:0]    csr_wdata;
    logic [XLEN-1:0]    csr_rdata;
    logic               int_sel, int_flush, in_handler;
    logic [XLEN-1:0]    pc_int;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_mie, m_mpie;
    logic [3:0]  m_mask;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_pcint;
    bit          m_redir, m_redir_ret, m_handler;

    always #5 clk = ~clk;

    csr_irq_ctrl #(
        .XLEN        (XLEN),
        .NUM_IRQ     (NUM_IRQ),
        .MTVEC_RESET (32'h0000_0004),
        .VECTORED_EN (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_m       (pc_m),
        .valid_m    (valid_m),
        .mret_m     (mret_m),
        .irq_i      (irq_i),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .int_sel    (int_sel),
        .int_flush  (int_flush),
        .pc_int     (pc_int),
        .in_handler (in_handler)
    );

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: model_read = (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: model_read = 32'(m_mask);
            12'h305: model_read = m_mtvec;
            12'h341: model_read = m_mepc;
            12'h342: model_read = m_mcause;
            12'h344: model_read = 32'(irq_i);
            default: model_read = 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0; m_mask = 4'h0;
        m_mtvec = 32'h4; m_mepc = 32'h0; m_mcause = 32'h0; m_pcint = 32'h0;
        m_redir = 1'b0; m_redir_ret = 1'b0; m_handler = 1'b0;
    endtask

    // One clock edge: the model applies the rules to the inputs seen at the edge
    task automatic tick();
        bit          was_redir, was_ret, idle, take, ret, old_mie, old_mpie;
        logic [3:0]  pend;
        int          id;
        logic [31:0] old_mepc, old_mtvec;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            was_redir = m_redir; was_ret = m_redir_ret;
            idle      = !m_redir && !m_handler;
            pend      = irq_i & m_mask;
            id        = 0;
            for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend[i]) id = i;
            take = idle && m_mie && valid_m && (pend != 4'h0) && !mret_m;
            ret  = !was_redir && valid_m && mret_m;
            old_mepc = m_mepc; old_mtvec = m_mtvec; old_mie = m_mie; old_mpie = m_mpie;
            if (csr_we) begin
                case (csr_addr)
                    12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                    12'h304: m_mask   = csr_wdata[3:0];
                    12'h305: m_mtvec  = csr_wdata & 32'hFFFF_FFFD;
                    12'h341: m_mepc   = csr_wdata & 32'hFFFF_FFFC;
                    12'h342: m_mcause = csr_wdata;
                    default: ;
                endcase
            end
            if (was_redir && was_ret) begin
                m_mie = old_mpie; m_mpie = 1'b1;
            end
            if (take) begin
                m_mepc   = pc_m;
                m_mcause = 32'h8000_0000 | 32'(id);
                m_mpie   = old_mie;
                m_mie    = 1'b0;
                m_pcint  = {old_mtvec[31:2], 2'b00}
                         + ((old_mtvec[1:0] == 2'b01) ? 32'(4 * id) : 32'h0);
            end
            if (ret) m_pcint = old_mepc;
            m_redir     = take || ret;
            m_redir_ret = ret;
            if (take)     m_handler = 1'b1;
            else if (ret) m_handler = 1'b0;
        end
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] addrs [6];
        logic [31:0] exp   [6];
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344};
        exp   = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0};
        reset = 1'b1; tick(); tick();
        reset = 1'b0; tick();
        for (int i = 0; i < 6; i++) begin
            csr_addr = addrs[i]; #1;
            checks++;
            if (csr_rdata !== exp[i]) begin
                failures++;
                $display("FAIL reset_csr addr=%h got=%h exp=%h", addrs[i], csr_rdata, exp[i]);
            end
        end
        checks++;
        if ({int_sel, int_flush, in_handler} !== 3'b000 || pc_int !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs sel/flush/hdl=%b%b%b pc_int=%h exp 000/0", int_sel, int_flush, in_handler, pc_int);
        end
    endtask

    task automatic test_direct_trap();
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h3);
        csr_write(12'h305, 32'h4);
        irq_i = 4'b0010; pc_m = 32'h40; valid_m = 1'b1;
        tick();
        irq_i = 4'b0000; valid_m = 1'b0;
        checks++;
        if (int_sel !== 1'b1 || int_flush !== 1'b1 || pc_int !== 32'h4) begin
            failures++;
            $display("FAIL direct_entry sel=%b flush=%b pc_int=%h exp 1/1/00000004", int_sel, int_flush, pc_int);
        end
        csr_addr = 12'h341; #1;
        checks++;
        if (csr_rdata !== 32'h40) begin
            failures++; $display("FAIL direct_mepc got=%h exp=00000040", csr_rdata);
        end
        csr_addr = 12'h342; #1;
        checks++;
        if (csr_rdata !== 32'h8000_0001) begin
            failures++; $display("FAIL direct_mcause got=%h exp=80000001", csr_rdata);
        end
        tick();
        checks++;
        if (int_sel !== 1'b0 || in_handler !== 1'b1) begin
            failures++; $display("FAIL direct_handler sel=%b hdl=%b exp 0/1", int_sel, in_handler);
        end
        valid_m = 1'b1; mret_m = 1'b1; tick();
        valid_m = 1'b0; mret_m = 1'b0;
        checks++;
        if (int_sel !== 1'b1 || pc_int !== 32'h40) begin
            failures++; $display("FAIL direct_mret sel=%b pc_int=%h exp 1/00000040", int_sel, pc_int);
        end
        tick();
        csr_addr = 12'h300; #1;
        checks++;
        if (int_sel !== 1'b0 || in_handler !== 1'b0 || csr_rdata !== 32'h88) begin
            failures++;
            $display("FAIL direct_after_ret sel=%b hdl=%b mstatus=%h exp 0/0/00000088", int_sel, in_handler, csr_rdata);
        end
    endtask

    task automatic test_vectored_no_nest();
        csr_write(12'h305, 32'h101);
        csr_write(12'h304, 32'hF);
        irq_i = 4'b0110; pc_m = 32'h40; valid_m = 1'b1;
        tick();
        irq_i = 4'b0000; valid_m = 1'b0;
        csr_addr = 12'h342; #1;
        checks++;
        if (int_sel !== 1'b1 || pc_int !== 32'h104 || csr_rdata !== 32'h8000_0001) begin
            failures++;
            $display("FAIL vectored_entry sel=%b pc_int=%h mcause=%h exp 1/00000104/80000001", int_sel, pc_int, csr_rdata);
        end
        irq_i = 4'b0001; pc_m = 32'h90; valid_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (int_sel !== 1'b0 || in_handler !== 1'b1 || pc_int !== 32'h104) begin
                failures++;
                $display("FAIL no_nest cyc=%0d sel=%b hdl=%b pc_int=%h exp 0/1/00000104", i, int_sel, in_handler, pc_int);
            end
        end
        irq_i = 4'b0000; mret_m = 1'b1; tick();
        valid_m = 1'b0; mret_m = 1'b0;
        checks++;
        if (int_sel !== 1'b1 || int_flush !== 1'b1 || pc_int !== 32'h40) begin
            failures++; $display("FAIL vectored_mret sel=%b flush=%b pc_int=%h exp 1/1/00000040", int_sel, int_flush, pc_int);
        end
        tick();
        csr_addr = 12'h300; #1;
        checks++;
        if (in_handler !== 1'b0 || csr_rdata[3] !== 1'b1) begin
            failures++; $display("FAIL vectored_after_ret hdl=%b mstatus=%h exp hdl 0, MIE 1", in_handler, csr_rdata);
        end
    endtask

    task automatic test_bubble();
        csr_write(12'h305, 32'h4);
        irq_i = 4'b0100; pc_m = 32'h200; valid_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (int_sel !== 1'b0 || in_handler !== 1'b0) begin
                failures++; $display("FAIL bubble_no_trap cyc=%0d sel=%b hdl=%b exp 0/0", i, int_sel, in_handler);
            end
        end
        valid_m = 1'b1; tick();
        irq_i = 4'b0000; valid_m = 1'b0;
        csr_addr = 12'h342; #1;
        checks++;
        if (int_sel !== 1'b1 || pc_int !== 32'h4 || csr_rdata !== 32'h8000_0002) begin
            failures++;
            $display("FAIL bubble_take sel=%b pc_int=%h mcause=%h exp 1/00000004/80000002", int_sel, pc_int, csr_rdata);
        end
        tick();
        csr_addr = 12'h300; #1;
        checks++;
        if (csr_rdata !== 32'h80) begin
            failures++; $display("FAIL handler_mstatus got=%h exp=00000080", csr_rdata);
        end
        valid_m = 1'b1; mret_m = 1'b1; tick();
        valid_m = 1'b0; mret_m = 1'b0; tick();
    endtask

    task automatic test_csr_masks();
        logic [11:0] addrs [5];
        logic [31:0] exp   [5];
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342};
        exp   = '{32'h88, 32'hF, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFFFF_FFFF};
        irq_i = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            csr_write(addrs[i], 32'hFFFF_FFFF);
            csr_addr = addrs[i]; #1;
            checks++;
            if (csr_rdata !== exp[i]) begin
                failures++; $display("FAIL csr_mask addr=%h got=%h exp=%h", addrs[i], csr_rdata, exp[i]);
            end
        end
        csr_write(12'h344, 32'hFFFF_FFFF);
        irq_i = 4'b1010; csr_addr = 12'h344; #1;
        checks++;
        if (csr_rdata !== 32'hA) begin
            failures++; $display("FAIL mip_read got=%h exp=0000000a", csr_rdata);
        end
        csr_addr = 12'h345; #1;
        checks++;
        if (csr_rdata !== 32'h0) begin
            failures++; $display("FAIL unmapped_read got=%h exp=00000000", csr_rdata);
        end
        irq_i = 4'b0000;
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic test_reset_in_trap();
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h1);
        irq_i = 4'b0001; pc_m = 32'h300; valid_m = 1'b1;
        tick();
        checks++;
        if (int_sel !== 1'b1) begin
            failures++; $display("FAIL rst_trap_entry sel=%b exp 1", int_sel);
        end
        irq_i = 4'b0000; valid_m = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        csr_addr = 12'h300; #1;
        checks++;
        if (int_sel !== 1'b0 || in_handler !== 1'b0 || pc_int !== 32'h0 || csr_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_in_trap sel=%b hdl=%b pc_int=%h mstatus=%h exp 0/0/0/0", int_sel, in_handler, pc_int, csr_rdata);
        end
        csr_addr = 12'h341; #1;
        checks++;
        if (csr_rdata !== 32'h0) begin
            failures++; $display("FAIL rst_in_trap_mepc got=%h exp=00000000", csr_rdata);
        end
    endtask

    task automatic test_random();
        logic [11:0] addrs [7];
        logic [31:0] exp_rd;
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h345};
        for (int n = 0; n < 2000; n++) begin
            reset   = ($urandom_range(0, 199) == 0);
            valid_m = ($urandom_range(0, 9) < 7);
            mret_m  = ($urandom_range(0, 11) == 0);
            irq_i   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            pc_m    = $urandom & 32'hFFFF_FFFC;
            csr_addr = addrs[$urandom_range(0, 6)];
            csr_we  = !valid_m && ($urandom_range(0, 4) == 0);
            csr_wdata = $urandom;
            if (csr_addr == 12'h300 && $urandom_range(0, 3) != 0) csr_wdata[3] = 1'b1;
            tick();
            exp_rd = model_read(csr_addr);
            checks++;
            if (int_sel !== m_redir || int_flush !== m_redir || in_handler !== m_handler) begin
                failures++;
                $display("FAIL rand_ctrl n=%0d sel/flush/hdl=%b%b%b exp %b%b%b", n, int_sel, int_flush, in_handler, m_redir, m_redir, m_handler);
            end
            checks++;
            if (pc_int !== m_pcint) begin
                failures++; $display("FAIL rand_pc_int n=%0d got=%h exp=%h", n, pc_int, m_pcint);
            end
            checks++;
            if (csr_rdata !== exp_rd) begin
                failures++; $display("FAIL rand_rdata n=%0d addr=%h got=%h exp=%h", n, csr_addr, csr_rdata, exp_rd);
            end
        end
        csr_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pc_m = 32'h0; valid_m = 1'b0; mret_m = 1'b0; irq_i = 4'h0;
        csr_we = 1'b0; csr_addr = 12'h300; csr_wdata = 32'h0;
        model_reset();
        test_reset();
        test_direct_trap();
        test_vectored_no_nest();
        test_bubble();
        test_csr_masks();
        test_reset_in_trap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_irq_ctrl.md
Name: csr_irq_ctrl

Overview:
- Parametrised interrupt/CSR controller for the 5-stage core.
- Arbitrates up to NUM_IRQ level-sensitive interrupt lines and takes the trap at the Memory stage.
- Saves the return PC (mepc) and cause (mcause), redirects fetch to the handler, and returns on mret.
- Holds mstatus.MIE/MPIE, mie and mtvec; supports direct and vectored handler modes.

Parameters:
- XLEN, 32, datapath/PC width.
- NUM_IRQ, 4, number of interrupt lines (1..16).
- MTVEC_RESET, 32'h0000_0004, reset value of the handler base.
- VECTORED_EN, 1, when 1 mtvec[1:0]==2'b01 selects vectored mode; when 0 mode bits are forced to 00.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pc_m  in  XLEN  PC of the instruction currently in the Memory stage.
- valid_m  in  1  Memory-stage instruction is valid, not a bubble.
- mret_m  in  1  Memory-stage instruction is mret; qualified by valid_m.
- irq_i  in  NUM_IRQ  level interrupt requests; bit 0 has the highest priority.
- csr_we  in  1  CSR write strobe.
- csr_addr  in  12  CSR address: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x344 mip (read-only).
- csr_wdata  in  XLEN  CSR write data.
- csr_rdata  out  XLEN  combinational read of csr_addr; 0 for unmapped addresses.
- int_sel  out  1  PC mux select: take pc_int this cycle.
- int_flush  out  1  flush the IF/ID/EX pipeline registers.
- pc_int  out  XLEN  redirect target.
- in_handler  out  1  high from trap entry until mret retires.

Behaviour:
- Reset values: mstatus.MIE=0, MPIE=0, mie=0, mtvec=MTVEC_RESET, mepc=0, mcause=0. FSM goes to IDLE; int_sel, int_flush and in_handler are 0; pc_int=0.
- Pending vector: pend = irq_i & mie[NUM_IRQ-1:0]. mip reads irq_i, zero-extended.
- Take condition: FSM==IDLE && MIE && valid_m && |pend && !mret_m. Bubbles are never trapped. Interrupt lines are not latched: a line dropped before it is taken is lost.
- Winner: the lowest set index in pend.
- FSM states: IDLE, TRAP, HANDLER, RET.
  - IDLE -> TRAP on the take condition. At the same edge: mepc<=pc_m, mcause<={1'b1, zero-extended winner id}, MPIE<=MIE, MIE<=0.
  - TRAP, one cycle: int_sel=1, int_flush=1. pc_int = {mtvec[XLEN-1:2],2'b00}, plus 4*id when vectored. Next state HANDLER.
  - HANDLER: in_handler=1. No new trap can be taken (MIE=0, no nesting). On valid_m && mret_m -> RET.
  - RET, one cycle: int_sel=1, int_flush=1, pc_int=mepc, MIE<=MPIE, MPIE<=1. Next state IDLE.
  - mret executed in IDLE returns to mepc through RET in the same way.
- Redirect latency: trap entry or mret seen at edge N -> int_sel/int_flush high for exactly the cycle after edge N. Otherwise int_sel=0, int_flush=0, and pc_int holds its last value.
- CSR writes take effect at the edge. Write masks:
  - mstatus: bits 3 (MIE) and 7 (MPIE) only.
  - mie: low NUM_IRQ bits only.
  - mtvec: all bits; bit 1 is forced to 0, and bit 0 is forced to 0 when VECTORED_EN=0.
  - mepc: bits [1:0] forced to 0.
  - mcause: full width.
- If a trap entry and a CSR write hit the same register at the same edge, the trap update wins.
- Reset while in TRAP, HANDLER or RET: the FSM goes to IDLE immediately, no redirect is issued, and all registers take their reset values.

Decomposition:
- Shared package csr_pkg: CSR address constants, mstatus bit indices (MIE=3, MPIE=7), the FSM state typedef, mtvec mode encodings, and the MCAUSE_INT bit position (XLEN-1).
- Sub-module irq_prio_enc: parametrised fixed-priority encoder from pend to {valid, id}.

Test Plan:
- Reset, then read every CSR -> mtvec=0x4, all others 0; int_sel=0.
- Set MIE=1, mie=4'b0011, direct mode; raise irq_i=4'b0010 with pc_m=0x40 and valid_m=1 -> next cycle int_sel=1, int_flush=1, pc_int=0x4; mepc=0x40, mcause=0x8000_0001.
- mtvec=0x101 (vectored); irq_i=4'b0110 with mie=4'b1111 -> id 1 wins, pc_int=0x104.
- In HANDLER, raise irq0 -> no redirect. Then mret_m with valid_m -> pc_int=0x40, MIE returns to 1, in_handler falls.
- irq pending with valid_m=0 for 3 cycles -> no trap; trap taken on the first cycle valid_m=1.
- Assert reset during TRAP -> the next cycle shows int_sel=0, FSM in IDLE and MIE=0.
